cga_trap_seq: RTL and testbench
===============================

# cga_trap_seq

Trap sequencer for the CGA trap path. It sits between the trap detector (`TRAPN`, `TVEC_3_0`, `BRKN`) and the microsequencer. It edge-detects trap and breakpoint events and buffers pending trap vectors in a 2-deep queue. It arbitrates breakpoint over queued traps and hands one microcode entry address at a time to the microsequencer, using a request/acknowledge/done handshake.

## Interface
Parameters:
- `TBASE`, 8'h80, microcode trap table base address
- `BRKVEC`, 4'hF, vector code used for breakpoint entry
- `QDEPTH`, 2, trap vector queue depth; fixed at 2, other values unsupported

Ports:
- `TCLK`  in  1  CPU clock; all state updates on its rising edge
- `RESET`  in  1  synchronous, active-high reset
- `TRAPN`  in  1  active-low trap indication from trap detector
- `TVEC_3_0`  in  4  trap vector, valid while `TRAPN` low
- `BRKN`  in  1  active-low breakpoint indication
- `MACK`  in  1  microsequencer accepts `TENTRY_7_0`
- `MDONE`  in  1  trap microroutine finished
- `TREQ`  out  1  entry request to microsequencer
- `TENTRY_7_0`  out  8  microcode entry address
- `TBUSY`  out  1  high in REQ or RUN
- `TOVF`  out  1  sticky queue overflow
- `TCNT_3_0`  out  4  serviced-trap counter (see Configuration)

## Operation
- Event detect: registered copies of `TRAPN` and `BRKN`. A trap event is a sample of `TRAPN`=0 when the previous sample was 1; same rule for breakpoint.
- Trap event: push `TVEC_3_0` into the queue. If the queue is full, drop the vector and set `TOVF`, which stays set until `RESET`.
- Breakpoint event: set `brk_pend`. A second breakpoint while pending merges into the one already pending (no overflow).
- Arbitration in IDLE:
  - `brk_pend` first, then the queue head.
  - Selected vector is held in `cur_vec` with flag `cur_brk`.
- Entry address: `TENTRY_7_0` = `TBASE` + {vec, 2'b00}, 8-bit, modulo 256. Examples: vec 3 → 8'h8C; `BRKVEC` → 8'hBC.
- FSM:
  - IDLE → REQ when `brk_pend` or queue non-empty. Selection is latched, and `TENTRY_7_0` is loaded from it.
  - REQ: `TREQ`=1, `TENTRY_7_0` held stable. `MACK`=1 → RUN. In the same edge, pop the queue, or clear `brk_pend` if `cur_brk`.
  - RUN: `TREQ`=0. `MDONE`=1 → IDLE and increment `TCNT_3_0`.
- `MACK` outside REQ and `MDONE` outside RUN are ignored.
- Push and pop on the same edge are legal: count is unchanged, and a push to a full queue succeeds when a pop happens on the same edge.
- Breakpoint event on the same edge as its clear (`MACK` with `cur_brk`): `brk_pend` stays set.
- Reset values: `TREQ`=0, `TENTRY_7_0`=8'h00, `TBUSY`=0, `TOVF`=0, `TCNT_3_0`=0, queue empty, `brk_pend`=0, state IDLE. Reset mid-handshake abandons the current entry.

## Timing
- Event sampled at edge k → queued/pending at edge k; IDLE→REQ at edge k+1; `TREQ` high after edge k+1. Minimum latency is 2 cycles from event to `TREQ`.
- `MACK` sampled at edge m → `TREQ` low after m.
- `MDONE` at edge d → IDLE after d. The next `TREQ` is no earlier than after edge d+1.
- All outputs are registered; no combinational input-to-output paths.
- `TCNT_3_0` wraps 15 → 0.

## Configuration
- `CGA_TRAP_SEQ_STATS_EN` defined: `TCNT_3_0` counts completed trap routines, as above.
- Not defined: the counter is not built and `TCNT_3_0` is tied to 4'h0.

## Structure
- Package `cga_trap_seq_pkg`:
  - state enum (IDLE, REQ, RUN)
  - default `TBASE` and `BRKVEC` constants
  - vector and entry widths
- Sub-module `cga_trap_seq_fifo`: 2-deep, 4-bit vector FIFO with push, pop, full, empty and head outputs.

## Test plan
- Single trap: `TRAPN` 1→0 with `TVEC_3_0`=3 → `TREQ` high 2 cycles later, `TENTRY_7_0`=8'h8C; `MACK` → `TREQ` low; `MDONE` → IDLE, `TCNT_3_0`=1.
- Priority: trap vec 5 and `BRKN` fall on the same edge → first entry 8'hBC; after `MDONE`, second entry 8'h94.
- Overflow: three trap events (vec 1, 2, 4) while in RUN → `TOVF`=1; later entries 8'h84 then 8'h88 only; vec 4 lost.
- Handshake hold: delay `MACK` 10 cycles → `TREQ` and `TENTRY_7_0` stable throughout; a spurious `MDONE` during REQ is ignored.
- Reset mid-RUN: `RESET` for 1 cycle → all outputs at reset values after the edge, queue empty, `TOVF`=0.
- Counter wrap (with `CGA_TRAP_SEQ_STATS_EN`): 16 complete traps → `TCNT_3_0`=0. Without the macro, `TCNT_3_0` stays 0 throughout.

Source files
------------

// File: rtl/cga_trap_seq_pkg.sv
// Shared types and constants for the CGA trap sequencer.
package cga_trap_seq_pkg;

  localparam int VEC_W   = 4;
  localparam int ENTRY_W = 8;

  localparam logic [ENTRY_W-1:0] TBASE_DEFAULT  = 8'h80;
  localparam logic [VEC_W-1:0]   BRKVEC_DEFAULT = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RUN  = 2'd2
  } trap_state_e;

  // Each trap table slot is four microwords wide; the sum wraps modulo 256.
  function automatic logic [ENTRY_W-1:0] entry_addr(input logic [ENTRY_W-1:0] base,
                                                     input logic [VEC_W-1:0]   vec);
    return base + {2'b00, vec, 2'b00};
  endfunction

endpackage

// File: rtl/cga_trap_seq_fifo.sv
// Small trap-vector FIFO; a push to a full FIFO succeeds when a pop lands on the same edge.
module cga_trap_seq_fifo
  import cga_trap_seq_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [VEC_W-1:0] din_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [VEC_W-1:0] head_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [VEC_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rdPtr_q, wrPtr_q;
  logic [CW-1:0]    cnt_q;
  logic             doPush, doPop;

  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rdPtr_q];
  assign doPop   = pop_i && !empty_o;
  assign doPush  = push_i && (!full_o || doPop);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      cnt_q   <= '0;
    end else begin
      if (doPush) wrPtr_q <= nextPtr(wrPtr_q);
      if (doPop)  rdPtr_q <= nextPtr(rdPtr_q);
      case ({doPush, doPop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset; the count alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (doPush) mem_q[wrPtr_q] <= din_i;
  end

endmodule

// File: rtl/cga_trap_seq.sv
// Trap sequencer: edge-detects traps/breakpoints and hands microcode entries to the microsequencer.
// Define CGA_TRAP_SEQ_STATS_EN to build the serviced-trap counter on TCNT_3_0.
module cga_trap_seq
  import cga_trap_seq_pkg::*;
#(
  parameter logic [ENTRY_W-1:0] TBASE  = TBASE_DEFAULT,
  parameter logic [VEC_W-1:0]   BRKVEC = BRKVEC_DEFAULT,
  parameter int                 QDEPTH = 2
) (
  input  logic               TCLK,
  input  logic               RESET,
  input  logic               TRAPN,
  input  logic [VEC_W-1:0]   TVEC_3_0,
  input  logic               BRKN,
  input  logic               MACK,
  input  logic               MDONE,
  output logic               TREQ,
  output logic [ENTRY_W-1:0] TENTRY_7_0,
  output logic               TBUSY,
  output logic               TOVF,
  output logic [3:0]         TCNT_3_0
);

  trap_state_e        state_q, state_d;
  logic               trapn_q, brkn_q;
  logic               brkPend_q, brkPend_d;
  logic               curBrk_q, curBrk_d;
  logic [ENTRY_W-1:0] entry_q, entry_d;
  logic               treq_q, tbusy_q, tovf_q;
  logic               trapEv, brkEv, qPop, brkClr, done;
  logic               qFull, qEmpty;
  logic [VEC_W-1:0]   qHead;

  assign trapEv = trapn_q && !TRAPN;
  assign brkEv  = brkn_q && !BRKN;

  cga_trap_seq_fifo #(.DEPTH(QDEPTH)) u_fifo (
    .clk_i   (TCLK),
    .reset_i (RESET),
    .push_i  (trapEv),
    .pop_i   (qPop),
    .din_i   (TVEC_3_0),
    .full_o  (qFull),
    .empty_o (qEmpty),
    .head_o  (qHead)
  );

  always_comb begin
    state_d  = state_q;
    curBrk_d = curBrk_q;
    entry_d  = entry_q;
    qPop     = 1'b0;
    brkClr   = 1'b0;
    done     = 1'b0;
    case (state_q)
      IDLE: begin
        if (brkPend_q || !qEmpty) begin
          state_d  = REQ;
          curBrk_d = brkPend_q;
          entry_d  = entry_addr(TBASE, brkPend_q ? BRKVEC : qHead);
        end
      end
      REQ: begin
        if (MACK) begin
          state_d = RUN;
          qPop    = !curBrk_q;
          brkClr  = curBrk_q;
        end
      end
      RUN: begin
        if (MDONE) begin
          state_d = IDLE;
          done    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A new breakpoint edge wins over the clear issued on acceptance.
  assign brkPend_d = brkEv ? 1'b1 : (brkClr ? 1'b0 : brkPend_q);

  always_ff @(posedge TCLK) begin
    if (RESET) begin
      state_q   <= IDLE;
      trapn_q   <= 1'b1;
      brkn_q    <= 1'b1;
      brkPend_q <= 1'b0;
      curBrk_q  <= 1'b0;
      entry_q   <= '0;
      treq_q    <= 1'b0;
      tbusy_q   <= 1'b0;
      tovf_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      trapn_q   <= TRAPN;
      brkn_q    <= BRKN;
      brkPend_q <= brkPend_d;
      curBrk_q  <= curBrk_d;
      entry_q   <= entry_d;
      treq_q    <= (state_d == REQ);
      tbusy_q   <= (state_d != IDLE);
      tovf_q    <= tovf_q | (trapEv && qFull && !qPop);
    end
  end

  assign TREQ       = treq_q;
  assign TENTRY_7_0 = entry_q;
  assign TBUSY      = tbusy_q;
  assign TOVF       = tovf_q;

`ifdef CGA_TRAP_SEQ_STATS_EN
  logic [3:0] tcnt_q;

  always_ff @(posedge TCLK) begin
    if (RESET)     tcnt_q <= 4'h0;
    else if (done) tcnt_q <= tcnt_q + 4'h1;
  end

  assign TCNT_3_0 = tcnt_q;
`else
  logic unusedDone;
  assign unusedDone = done;
  assign TCNT_3_0   = 4'h0;
`endif

endmodule

// File: tb/tb_cga_trap_seq.sv
// Self-checking bench for cga_trap_seq: queue-based reference model plus directed scenarios.
module tb_cga_trap_seq;

`ifdef CGA_TRAP_SEQ_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic       TCLK = 1'b0;
  logic       RESET, TRAPN, BRKN, MACK, MDONE;
  logic [3:0] TVEC_3_0;
  logic       TREQ, TBUSY, TOVF;
  logic [7:0] TENTRY_7_0;
  logic [3:0] TCNT_3_0;

  int checks = 0;
  int errors = 0;
  bit checkEn = 1'b0;

  cga_trap_seq dut (
    .TCLK       (TCLK),
    .RESET      (RESET),
    .TRAPN      (TRAPN),
    .TVEC_3_0   (TVEC_3_0),
    .BRKN       (BRKN),
    .MACK       (MACK),
    .MDONE      (MDONE),
    .TREQ       (TREQ),
    .TENTRY_7_0 (TENTRY_7_0),
    .TBUSY      (TBUSY),
    .TOVF       (TOVF),
    .TCNT_3_0   (TCNT_3_0)
  );

  always #5 TCLK = ~TCLK;

  // Reference model: pending work as a queue of vectors plus a breakpoint flag;
  // the handshake is tracked only as "waiting for accept" / "routine running".
  int         mQ[$];
  bit         mBrk, mWaiting, mRunning, mCurIsBrk, mOvf;
  bit         mPrevTrapn = 1'b1, mPrevBrkn = 1'b1;
  logic [7:0] mEntry;
  int         mDone;

  function automatic logic [7:0] entryOf(input int vec);
    return 8'((128 + vec * 4) % 256);
  endfunction

  always @(posedge TCLK) begin
    if (RESET) begin
      mQ.delete();
      mBrk = 0; mWaiting = 0; mRunning = 0; mCurIsBrk = 0; mOvf = 0;
      mPrevTrapn = 1; mPrevBrkn = 1; mEntry = 8'h00; mDone = 0;
    end else begin
      bit trapEv, brkEv, popNow, clearNow;
      trapEv   = !TRAPN && mPrevTrapn;
      brkEv    = !BRKN && mPrevBrkn;
      popNow   = 0;
      clearNow = 0;
      if (mRunning) begin
        if (MDONE) begin
          mRunning = 0;
          mDone++;
        end
      end else if (mWaiting) begin
        if (MACK) begin
          mWaiting = 0;
          mRunning = 1;
          if (mCurIsBrk) clearNow = 1; else popNow = 1;
        end
      end else if (mBrk || mQ.size() > 0) begin
        mWaiting  = 1;
        mCurIsBrk = mBrk;
        mEntry    = mBrk ? entryOf(15) : entryOf(mQ[0]);
      end
      if (popNow) void'(mQ.pop_front());
      if (trapEv) begin
        if (mQ.size() < 2) mQ.push_back(int'(TVEC_3_0));
        else mOvf = 1;
      end
      if (clearNow) mBrk = 0;
      if (brkEv) mBrk = 1;
      mPrevTrapn = TRAPN;
      mPrevBrkn  = BRKN;
    end
  end

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge TCLK) begin
    if (checkEn) begin
      checkOutput("model TREQ",   {7'd0, TREQ},  {7'd0, mWaiting});
      checkOutput("model TBUSY",  {7'd0, TBUSY}, {7'd0, (mWaiting || mRunning)});
      checkOutput("model TENTRY", TENTRY_7_0, mEntry);
      checkOutput("model TOVF",   {7'd0, TOVF},  {7'd0, mOvf});
      checkOutput("model TCNT",   {4'd0, TCNT_3_0}, STATS ? 8'(mDone % 16) : 8'h00);
    end
  end

  task automatic tick();
    @(posedge TCLK);
    #1;
  endtask

  task automatic applyStimulus(input bit trap, input bit brk, input logic [3:0] vec);
    TVEC_3_0 = vec;
    TRAPN    = !trap;
    BRKN     = !brk;
    tick();
    TRAPN = 1'b1;
    BRKN  = 1'b1;
    tick();
  endtask

  task automatic waitReq(input string name);
    int n;
    n = 0;
    while (TREQ !== 1'b1 && n < 20) begin
      @(negedge TCLK);
      n++;
    end
    if (TREQ !== 1'b1) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: TREQ got %b expected 1 within 20 cycles", name, TREQ);
    end
  endtask

  task automatic doAck();
    MACK = 1'b1;
    tick();
    MACK = 1'b0;
  endtask

  task automatic doDone();
    MDONE = 1'b1;
    tick();
    MDONE = 1'b0;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " TREQ"},   {7'd0, TREQ},  8'h00);
    checkOutput({tag, " TENTRY"}, TENTRY_7_0,    8'h00);
    checkOutput({tag, " TBUSY"},  {7'd0, TBUSY}, 8'h00);
    checkOutput({tag, " TOVF"},   {7'd0, TOVF},  8'h00);
    checkOutput({tag, " TCNT"},   {4'd0, TCNT_3_0}, 8'h00);
  endtask

  initial begin
    RESET = 1'b1; TRAPN = 1'b1; BRKN = 1'b1; MACK = 1'b0; MDONE = 1'b0; TVEC_3_0 = 4'h0;
    tick(); tick();
    RESET = 1'b0;
    checkResetValues("reset");
    checkEn = 1'b1;

    // Single trap: two cycles from event to request.
    TVEC_3_0 = 4'd3; TRAPN = 1'b0;
    tick();
    TRAPN = 1'b1;
    checkOutput("single TREQ after k", {7'd0, TREQ}, 8'h00);
    tick();
    checkOutput("single TREQ after k+1", {7'd0, TREQ}, 8'h01);
    checkOutput("single entry", TENTRY_7_0, 8'h8C);
    doAck();
    checkOutput("single TREQ after ack", {7'd0, TREQ}, 8'h00);
    checkOutput("single TBUSY in run", {7'd0, TBUSY}, 8'h01);
    doDone();
    checkOutput("single TBUSY idle", {7'd0, TBUSY}, 8'h00);
    checkOutput("single TCNT", {4'd0, TCNT_3_0}, STATS ? 8'h01 : 8'h00);

    // Breakpoint beats a trap arriving on the same edge.
    applyStimulus(1'b1, 1'b1, 4'd5);
    waitReq("priority first");
    checkOutput("priority first entry", TENTRY_7_0, 8'hBC);
    doAck(); doDone();
    waitReq("priority second");
    checkOutput("priority second entry", TENTRY_7_0, 8'h94);
    doAck(); doDone();

    // Overflow: three traps while a routine runs; the third is dropped.
    applyStimulus(1'b1, 1'b0, 4'd7);
    waitReq("overflow setup");
    doAck();
    applyStimulus(1'b1, 1'b0, 4'd1);
    applyStimulus(1'b1, 1'b0, 4'd2);
    checkOutput("overflow not yet", {7'd0, TOVF}, 8'h00);
    applyStimulus(1'b1, 1'b0, 4'd4);
    checkOutput("overflow TOVF", {7'd0, TOVF}, 8'h01);
    doDone();
    waitReq("overflow entry1");
    checkOutput("overflow entry1", TENTRY_7_0, 8'h84);
    doAck(); doDone();
    waitReq("overflow entry2");
    checkOutput("overflow entry2", TENTRY_7_0, 8'h88);
    doAck(); doDone();
    tick(); tick(); tick();
    checkOutput("overflow vec4 lost", {7'd0, TBUSY}, 8'h00);

    // Handshake hold with a spurious MDONE during REQ.
    applyStimulus(1'b1, 1'b0, 4'd6);
    waitReq("hold");
    for (int i = 0; i < 10; i++) begin
      MDONE = (i == 3);
      tick();
      checkOutput("hold TREQ", {7'd0, TREQ}, 8'h01);
      checkOutput("hold entry", TENTRY_7_0, 8'h98);
    end
    MDONE = 1'b0;
    doAck(); doDone();

    // Breakpoint edge on the same edge as its own acceptance stays pending.
    applyStimulus(1'b0, 1'b1, 4'd0);
    waitReq("brk rearm first");
    BRKN = 1'b0;
    doAck();
    BRKN = 1'b1;
    doDone();
    waitReq("brk rearm second");
    checkOutput("brk rearm entry", TENTRY_7_0, 8'hBC);
    doAck(); doDone();

    // Reset in the middle of a routine with another trap queued.
    applyStimulus(1'b1, 1'b0, 4'd2);
    applyStimulus(1'b1, 1'b0, 4'd9);
    waitReq("reset setup");
    doAck();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    checkResetValues("midrun reset");
    tick(); tick(); tick();
    checkOutput("midrun queue empty", {7'd0, TBUSY}, 8'h00);

    // Sixteen complete routines wrap the counter back to zero.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 1'b0, 4'(i));
      waitReq("wrap");
      doAck(); doDone();
      if (i == 0) checkOutput("wrap first count", {4'd0, TCNT_3_0}, STATS ? 8'h01 : 8'h00);
    end
    checkOutput("wrap TCNT", {4'd0, TCNT_3_0}, 8'h00);
    checkOutput("wrap last entry", TENTRY_7_0, 8'hBC);

    tick();
    checkEn = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "[TB] watchdog");
  end

endmodule
